// File: rtl/fullword_merge4_sync.sv
// Four-channel dual-rail NCL word merge into one synchronous stream, strict S,T,U,V ring order.
// Optional protocol checking enabled by defining FULLWORD_MERGE_CHECK_EN.

module fullword_merge4_pair (
    input  logic [1:0] rails,
    output logic       cmpl,
    output logic       nz,
    output logic       ill
);
    assign cmpl = rails[0] ^ rails[1];
    assign nz   = |rails;
    assign ill  = &rails;
endmodule

module fullword_merge4_sync #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               init,
    input  logic [2*WIDTH-1:0] s_in,
    input  logic [2*WIDTH-1:0] t_in,
    input  logic [2*WIDTH-1:0] u_in,
    input  logic [2*WIDTH-1:0] v_in,
    output logic [3:0]         ch_en,
    input  logic               z_en,
    output logic [2*WIDTH-1:0] z_out,
    output logic [3:0]         steer,
    output logic               done,
    output logic [CNT_W-1:0]   count,
    output logic               err
);
    typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

    state_t             state, state_n;
    logic [2*WIDTH-1:0] sel, z_out_n;
    logic [3:0]         ch_en_n, steer_n;
    logic [CNT_W-1:0]   count_n;
    logic               done_n, err_n;
    logic [WIDTH-1:0]   cmpl_v, nz_v, ill_v;
    logic               is_cmpl, is_null, is_ill;

    // steer is one-hot, so an AND-OR mux is enough
    assign sel = ({2*WIDTH{steer[0]}} & s_in) | ({2*WIDTH{steer[1]}} & t_in)
               | ({2*WIDTH{steer[2]}} & u_in) | ({2*WIDTH{steer[3]}} & v_in);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pair
        fullword_merge4_pair u_pair (
            .rails (sel[2*i +: 2]),
            .cmpl  (cmpl_v[i]),
            .nz    (nz_v[i]),
            .ill   (ill_v[i])
        );
    end

    assign is_cmpl = &cmpl_v;
    assign is_null = ~|nz_v;
    assign is_ill  = |ill_v;

    always_comb begin
        state_n = state;
        z_out_n = z_out;
        ch_en_n = ch_en;
        steer_n = steer;
        count_n = count;
        done_n  = 1'b0;
        case (state)
            WAIT_DATA: if (is_cmpl && z_en) begin
                z_out_n = sel;
                ch_en_n = ch_en & ~steer;
                count_n = count + CNT_W'(1);
                state_n = WAIT_NULL;
            end
            WAIT_NULL: if (is_null && !z_en) begin
                z_out_n = '0;
                ch_en_n = 4'hF;
                done_n  = 1'b1;
                steer_n = {steer[2:0], steer[3]};
                state_n = WAIT_DATA;
            end
            default: state_n = WAIT_DATA;
        endcase
    end

`ifdef FULLWORD_MERGE_CHECK_EN
    // DATA changing in WAIT_NULL without first returning to NULL is a protocol break
    assign err_n = err | is_ill | ((state == WAIT_NULL) && !is_null && (sel != z_out));
`else
    assign err_n = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (init) begin
            state <= WAIT_DATA;
            z_out <= '0;
            ch_en <= 4'hF;
            steer <= 4'b0001;
            done  <= 1'b0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            z_out <= z_out_n;
            ch_en <= ch_en_n;
            steer <= steer_n;
            done  <= done_n;
            count <= count_n;
            err   <= err_n;
        end
    end
endmodule
